uart_bus_bridge: RTL
====================

# uart_bus_bridge

Serial-to-bus debug bridge and the initiator counterpart of the memory-mapped UART peripheral. It receives framed command bytes on a UART line and decodes them into single-cycle reads and writes as master on the IO interconnect. It returns acknowledgements and read data over UART. It sits between an external host or debugger and the IO bus, so software-free peek/poke and boot loading are possible.

## Interface
- BAUD_DIVISOR, 650, clocks per baud tick minus one (9600 baud at the standard SoC clock)
- RD_LATENCY, 1, cycles from read strobe to valid io_bus_m_rd_data (1..4)
- TIMEOUT_CYCLES, 1_000_000, inter-byte idle limit while collecting arguments
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- uart_rx  in  1  serial input from host
- uart_tx  out  1  serial output to host
- io_bus_m_cs  out  1  chip select, one-cycle pulse per access
- io_bus_m_rd_en  out  1  read strobe, coincident with cs
- io_bus_m_wr_en  out  1  write strobe, coincident with cs
- io_bus_m_address  out  32  access address
- io_bus_m_wr_data  out  32  write data
- io_bus_m_rd_data  in  32  read data from the interconnect
- busy  out  1  high in any state other than IDLE

## Operation
- Baud divisor counter: counts 0..BAUD_DIVISOR and wraps. baud_pulse is high when the count equals 1. It drives instances of uart_rx and uart_tx. Those instances get rst = ~rst_n. All bridge flops reset asynchronously on rst_n low.
- Frame formats (multi-byte fields are LSB first):
  - Write: 0x57 ('W'), addr[4], data[4]. Reply: 0x06.
  - Read: 0x52 ('R'), addr[4]. Reply: data[4].
  - Any other command byte: reply 0x15 (NAK), then return to IDLE.
- FSM states: IDLE, ARGS, BUS_WR, BUS_RD, RD_WAIT, REPLY.
  - IDLE: on rx_done, latch the command.
    - W or R: go to ARGS with byte counter = 8 or 4.
    - Any other byte: load NAK and go to REPLY.
  - ARGS: each rx_done shifts the byte into the address/data shift registers and decrements the counter. When the counter reaches 0, go to BUS_WR (W) or BUS_RD (R).
  - BUS_WR: assert cs and wr_en for exactly one cycle. Load reply 0x06 (length 1). Go to REPLY.
  - BUS_RD: assert cs and rd_en for exactly one cycle. Go to RD_WAIT.
  - RD_WAIT: count RD_LATENCY cycles, capture io_bus_m_rd_data into the reply register (length 4), then go to REPLY.
  - REPLY: hold tx_start high with tx_data = current reply byte. On each uart_tx_done, advance to the next byte. After the last byte, go to IDLE.
- rx_done outside IDLE and ARGS is discarded. The block has no receive buffering.
- io_bus_m_address and io_bus_m_wr_data hold their last values between accesses.

## Timing
- Reset values:
  - uart_tx = 1.
  - cs, rd_en, wr_en = 0.
  - address and wr_data = 0.
  - busy = 0.
  - State = IDLE, divisor = 0.
- The bus strobe goes high on the cycle after the rx_done of the final argument byte. The strobe lasts 1 cycle.
- Read capture happens RD_LATENCY cycles after the strobe cycle. With RD_LATENCY=1, capture is on the cycle right after the strobe.
- Reply start: tx_start rises on the cycle after the write strobe or after the read capture.
- rst_n low mid-frame: strobes drop immediately. Partial arguments are lost. uart_tx returns to 1 at the next clk edge (the sub-blocks use a synchronous reset).
- rx_done coincident with the last uart_tx_done in REPLY: the byte is discarded.

## Configuration
- UART_BRIDGE_TIMEOUT_EN defined:
  - In ARGS, an idle counter clears on every rx_done.
  - If it reaches TIMEOUT_CYCLES, the bridge drops the partial frame and returns to IDLE. No bus access and no reply occur.
- UART_BRIDGE_TIMEOUT_EN undefined: ARGS waits indefinitely. The counter logic is not compiled.

## Test plan
- Write: send 57 10 00 00 80 EF BE AD DE -> one cycle of cs=wr_en=1 with address=0x80000010 and wr_data=0xDEADBEEF; then host receives 06.
- Read: send 52 04 00 00 80, model returns 0x12345678 one cycle after the strobe -> one rd_en pulse with address=0x80000004; host receives 78 56 34 12.
- Unknown command: send 41 -> no bus strobe; host receives 15; bridge is back in IDLE, and a following write succeeds.
- Timeout (macro defined, TIMEOUT_CYCLES=5000): send 57 01 02, then stay idle for 6000 cycles -> busy=0, no strobe; then a full read frame works normally.
- Byte during reply: send a read frame, then send 57 while the reply is in flight -> the 57 is ignored; exactly 4 reply bytes arrive, and no write occurs.
- Reset mid-frame: pull rst_n low after 3 bytes of a write frame -> strobes stay 0 and busy=0 asynchronously; a fresh write frame completes with the correct address and data.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART command decoder acting as IO bus master for peek/poke and boot loading.
// Define UART_BRIDGE_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES of line idle.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    output logic       done,
    output logic [7:0] data
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t  st;
    logic [1:0] sync;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    // tick is 16x the bit rate; bits are sampled mid-bit, 8 ticks after the start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= R_IDLE;
            sync <= 2'b11;
            tcnt <= '0;
            bcnt <= '0;
            done <= 1'b0;
            data <= '0;
        end else begin
            sync <= {sync[0], rx};
            done <= 1'b0;
            case (st)
                R_IDLE: if (!sync[1]) begin
                    st   <= R_START;
                    tcnt <= '0;
                end
                R_START: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd7) begin
                        st   <= sync[1] ? R_IDLE : R_DATA;
                        tcnt <= '0;
                        bcnt <= '0;
                    end
                end
                R_DATA: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        data <= {sync[1], data[7:1]};
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) st <= R_STOP;
                    end
                end
                R_STOP: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        st   <= R_IDLE;
                        done <= sync[1];
                    end
                end
                default: st <= R_IDLE;
            endcase
        end
    end
endmodule

module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    logic       act;
    logic [9:0] sh;
    logic [3:0] tcnt;
    logic [3:0] bcnt;
    // done is combinational so a held start sees the next byte, not a repeat of this one
    assign done = act && tick && tcnt == 4'd15 && bcnt == 4'd9;
    assign tx   = act ? sh[0] : 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            act  <= 1'b0;
            sh   <= '1;
            tcnt <= '0;
            bcnt <= '0;
        end else if (!act) begin
            if (start) begin
                act  <= 1'b1;
                sh   <= {1'b1, data, 1'b0};
                tcnt <= '0;
                bcnt <= '0;
            end
        end else if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
                sh   <= {1'b1, sh[9:1]};
                bcnt <= bcnt + 4'd1;
                if (bcnt == 4'd9) act <= 1'b0;
            end
        end
    end
endmodule

module uart_bus_bridge #(
    parameter int unsigned BAUD_DIVISOR   = 650,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        io_bus_m_cs,
    output logic        io_bus_m_rd_en,
    output logic        io_bus_m_wr_en,
    output logic [31:0] io_bus_m_address,
    output logic [31:0] io_bus_m_wr_data,
    input  logic [31:0] io_bus_m_rd_data,
    output logic        busy
);
    localparam int DW = $clog2(BAUD_DIVISOR + 2);
    typedef enum logic [2:0] {IDLE, ARGS, BUS_WR, BUS_RD, RD_WAIT, REPLY} state_t;
    state_t        state, state_nx;
    logic [DW-1:0] div;
    logic          baud_pulse;
    logic          rx_done, tx_start, tx_done, is_wr, timeout;
    logic [7:0]    rx_data;
    logic [3:0]    cnt;
    logic [55:0]   sh;
    logic [63:0]   full;
    logic [31:0]   reply;
    logic [2:0]    rlen;
    logic [2:0]    lat;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) div <= '0;
        else div <= (div == DW'(BAUD_DIVISOR)) ? '0 : div + DW'(1);
    assign baud_pulse = div == DW'(1);

    uart_rx u_rx (
        .clk  (clk),
        .rst  (~rst_n),
        .tick (baud_pulse),
        .rx   (uart_rx),
        .done (rx_done),
        .data (rx_data)
    );

    uart_tx u_tx (
        .clk   (clk),
        .rst   (~rst_n),
        .tick  (baud_pulse),
        .start (tx_start),
        .data  (reply[7:0]),
        .tx    (uart_tx),
        .done  (tx_done)
    );

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] idle_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idle_cnt <= '0;
        else idle_cnt <= (state != ARGS || rx_done) ? '0 : idle_cnt + 32'd1;
    assign timeout = idle_cnt == 32'(TIMEOUT_CYCLES);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_done) state_nx = (rx_data == 8'h57 || rx_data == 8'h52) ? ARGS : REPLY;
            ARGS:    if (timeout) state_nx = IDLE;
                     else if (rx_done && cnt == 4'd1) state_nx = is_wr ? BUS_WR : BUS_RD;
            BUS_WR:  state_nx = REPLY;
            BUS_RD:  state_nx = RD_WAIT;
            RD_WAIT: if (lat == 3'(RD_LATENCY)) state_nx = REPLY;
            REPLY:   if (tx_done && rlen == 3'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        io_bus_m_cs    = state == BUS_WR || state == BUS_RD;
        io_bus_m_wr_en = state == BUS_WR;
        io_bus_m_rd_en = state == BUS_RD;
        tx_start       = state == REPLY;
        busy           = state != IDLE;
    end

    // final argument byte completes the frame: W -> {data, addr}, R -> addr in the top word
    assign full = {rx_data, sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr            <= 1'b0;
            cnt              <= '0;
            sh               <= '0;
            reply            <= '0;
            rlen             <= '0;
            lat              <= '0;
            io_bus_m_address <= '0;
            io_bus_m_wr_data <= '0;
        end else begin
            if (state == IDLE && rx_done) begin
                is_wr <= rx_data == 8'h57;
                cnt   <= (rx_data == 8'h57) ? 4'd8 : 4'd4;
                reply <= 32'h15;
                rlen  <= 3'd1;
            end
            if (state == ARGS && rx_done) begin
                sh  <= {rx_data, sh[55:8]};
                cnt <= cnt - 4'd1;
            end
            if (state == ARGS && state_nx == BUS_WR) begin
                io_bus_m_address <= full[31:0];
                io_bus_m_wr_data <= full[63:32];
            end
            if (state == ARGS && state_nx == BUS_RD) io_bus_m_address <= full[63:32];
            if (state == BUS_WR) begin
                reply <= 32'h06;
                rlen  <= 3'd1;
            end
            if (state == BUS_RD) lat <= 3'd1;
            if (state == RD_WAIT && lat == 3'(RD_LATENCY)) begin
                reply <= io_bus_m_rd_data;
                rlen  <= 3'd4;
            end else if (state == RD_WAIT) lat <= lat + 3'd1;
            if (state == REPLY && tx_done) begin
                reply <= reply >> 8;
                rlen  <= rlen - 3'd1;
            end
        end
    end
endmodule
